data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised single-port synchronous data memory with a valid/ready request interface, 1-cycle registered read response, and a hardware clear sequence after reset. Next generation of the CPU data memory: width and depth are configurable, and out-of-range accesses are flagged. Sits between the load/store unit and storage.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read response valid (single-cycle pulse)
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  the response is for an out-of-range address
init_done  out  1  clear sequence complete

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. FSM enters CLEAR with clr_ptr=0.
- FSM has two states.
  - CLEAR: writes INIT_VAL to word clr_ptr each cycle and increments clr_ptr. On the cycle clr_ptr==DEPTH-1 is written, moves to RUN. CLEAR lasts exactly DEPTH cycles. req_ready=0 throughout, and requests are ignored.
  - RUN: init_done=1 and req_ready=1 every cycle. Stays in RUN until rst.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. One request per cycle; back-to-back accepts are allowed.
- Write (req_we=1, req_addr<DEPTH): mem[req_addr] is updated at the accept edge. No response is generated.
- Read (req_we=0): rsp_valid=1 in the cycle after the accept edge. rsp_rdata = mem[req_addr] as it stands after all earlier accepted writes. A write accepted in cycle N is visible to a read accepted in cycle N+1.
- Out of range (req_addr>=DEPTH):
  - A write is dropped; memory is unchanged and no response is generated.
  - A read gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- There is no response backpressure; the consumer must accept every response.
- Between reads, rsp_valid=0, and rsp_rdata and rsp_err hold their last values.
- rst asserted in any state, including mid-CLEAR or with a response pending:
  - the pending response is cancelled (rsp_valid=0 on the next cycle);
  - the FSM restarts CLEAR at address 0, so all prior contents are lost.
- DEPTH not a power of two: clr_ptr and address comparisons use ADDR_W+1 bits, so no wrap occurs.

Optional Feature:
DMEM_OUT_REG_EN
- Defined: an additional output register stage sits after the read register. Read latency becomes 2 cycles; rsp_valid, rsp_rdata and rsp_err are delayed together. Throughput is still one request per cycle, and reset clears both stages.
- Undefined: read latency is 1 cycle, as specified above.

Decomposition:
- Package dmem_pkg holds:
  - the FSM state enum {ST_CLEAR, ST_RUN};
  - default constants DMEM_DATA_W=8 and DMEM_ADDR_W=8;
  - the response latency localparam, derived from DMEM_OUT_REG_EN.
- Sub-module dmem_array: plain DEPTH x DATA_W storage with one synchronous write port and one registered read port, no reset on its contents. It is instantiated once.
- The controller owns the FSM, the clear mux, range checking and the response registers.

Test Plan:
1. Defaults. Release rst → req_ready=0 and init_done=0 for 256 cycles, and both rise on cycle 256. Then read 0x10 → one cycle later rsp_valid=1, rsp_rdata=0x00, rsp_err=0.
2. Write 0xA5 to 0x3C, then read 0x3C in the next cycle → rsp_valid=1 one cycle after the read accept, with rsp_rdata=0xA5.
3. Back-to-back on consecutive cycles: write 0x11@5, read 5, write 0x22@5, read 5 → two responses, 0x11 then 0x22, each arriving one cycle after its read.
4. DEPTH=200. Write 0x77@250, then read 250 → rsp_err=1, rsp_rdata=0. Then write 0x5A@199 and read 199 → 0x5A with rsp_err=0.
5. Reset scenarios:
   - Assert rst at CLEAR cycle 100 → CLEAR restarts, and init_done rises 256 cycles after rst deasserts.
   - Write 0xFF@7, issue a read, and assert rst in the next cycle → no rsp_valid, and after CLEAR a read of 7 returns 0x00.
6. With DMEM_OUT_REG_EN defined, repeat test 2 → rsp_valid arrives 2 cycles after the read accept with rsp_rdata=0xA5. Stream 4 reads to addresses 0–3 on consecutive cycles → 4 consecutive responses in order.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data memory controller.
//   dmem_state_e  : controller FSM states (clear sequence, normal operation)
//   DMEM_DATA_W   : default word width
//   DMEM_ADDR_W   : default address width
//   DMEM_RSP_LAT  : read response latency in cycles. It is 2 when the optional
//                   output register stage is built (macro DMEM_OUT_REG_EN is
//                   defined), otherwise 1.
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 8;

`ifdef DMEM_OUT_REG_EN
    localparam int DMEM_RSP_LAT = 2;
`else
    localparam int DMEM_RSP_LAT = 1;
`endif

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Plain DEPTH x DATA_W storage. It has one synchronous write port and one
// registered read port. The storage contents are never reset. Only the read
// data register is reset, so that the read data output starts at zero.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (read data register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable. When re is low, the read register holds its value.
//   raddr  : read address
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Synchronous write port. The caller guarantees that waddr < DEPTH.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port. The caller guarantees that raddr < DEPTH when re is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Single-port synchronous data memory with a valid/ready request interface.
// After reset, a hardware clear sequence writes INIT_VAL to every word. This
// takes DEPTH cycles. After that, the controller accepts one request per cycle.
// Reads return a registered response. An access to an address >= DEPTH is
// flagged: an out-of-range write is dropped, and an out-of-range read returns
// zero with rsp_err set.
// Optional build macro DMEM_OUT_REG_EN adds an output register stage, which
// makes the read latency 2 cycles.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset. It restarts the clear sequence.
//   req_valid  : request present
//   req_ready  : request can be accepted (RUN state only)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : single-cycle read response strobe
//   rsp_rdata  : read data. It holds its value between responses.
//   rsp_err    : the response is for an out-of-range address. It holds its value between responses.
//   init_done  : the clear sequence has finished
// -----------------------------------------------------------------------------
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int                DATA_W   = DMEM_DATA_W,
    parameter int                ADDR_W   = DMEM_ADDR_W,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    // Compare with one extra bit, so that DEPTH == 2**ADDR_W can be represented
    // and no wrap can occur.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);

    dmem_state_e       state_r;
    logic [ADDR_W:0]   clr_ptr_r;
    logic              req_ready_r;
    logic              init_done_r;

    logic              in_range_s;
    logic              accept_s;
    logic              rd_accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] arr_rdata_s;

    logic              rsp1_valid_r;
    logic              rsp1_err_r;
    logic [DATA_W-1:0] rsp1_rdata_s;

    assign in_range_s  = ({1'b0, req_addr} < DEPTH_X);
    // req_ready_r is high only in RUN, so this also ignores requests during CLEAR.
    assign accept_s    = req_valid & req_ready_r;
    assign rd_accept_s = accept_s & ~req_we;

    // Write-port mux: the clear sequence owns the array in CLEAR, and accepted
    // in-range writes own it in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_r[ADDR_W-1:0];
            mem_wdata_s = INIT_VAL;
        end else begin
            mem_we_s    = accept_s & req_we & in_range_s;
            mem_waddr_s = req_addr;
            mem_wdata_s = req_wdata;
        end
    end

    // Controller FSM: the clear sequence walks every word once, then the controller stays in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_CLEAR;
            clr_ptr_r   <= '0;
            req_ready_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_ptr_r == LAST_X) begin
                        state_r     <= ST_RUN;
                        clr_ptr_r   <= '0;
                        req_ready_r <= 1'b1;
                        init_done_r <= 1'b1;
                    end else begin
                        clr_ptr_r   <= clr_ptr_r + ONE_X;
                    end
                end
                ST_RUN: begin
                    req_ready_r <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_ptr_r   <= '0;
                    req_ready_r <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .re    (rd_accept_s & in_range_s),
        .raddr (req_addr),
        .rdata (arr_rdata_s)
    );

    // First response stage: the valid strobe, plus an error flag that is updated only on accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid_r <= 1'b0;
            rsp1_err_r   <= 1'b0;
        end else begin
            rsp1_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rsp1_err_r <= ~in_range_s;
            end
        end
    end

    // Out-of-range reads return zero. Both mux inputs are registers that hold
    // their values between reads, so the result also holds.
    always_comb begin
        rsp1_rdata_s = '0;
        if (rsp1_err_r) begin
            rsp1_rdata_s = '0;
        end else begin
            rsp1_rdata_s = arr_rdata_s;
        end
    end

`ifdef DMEM_OUT_REG_EN
    logic              rsp2_valid_r;
    logic              rsp2_err_r;
    logic [DATA_W-1:0] rsp2_rdata_r;

    // Optional output stage: it delays the whole response by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp2_valid_r <= 1'b0;
            rsp2_err_r   <= 1'b0;
            rsp2_rdata_r <= '0;
        end else begin
            rsp2_valid_r <= rsp1_valid_r;
            rsp2_err_r   <= rsp1_err_r;
            rsp2_rdata_r <= rsp1_rdata_s;
        end
    end

    assign rsp_valid = rsp2_valid_r;
    assign rsp_err   = rsp2_err_r;
    assign rsp_rdata = rsp2_rdata_r;
`else
    assign rsp_valid = rsp1_valid_r;
    assign rsp_err   = rsp1_err_r;
    assign rsp_rdata = rsp1_rdata_s;
`endif

    assign req_ready = req_ready_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed bench for data_memory_ctrl. dut_a uses the default geometry
// (DEPTH 256). dut_b uses DEPTH 200 for the range-check cases. Both share
// the clock and reset. Inputs are driven, and outputs are sampled, on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

`ifdef DMEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_valid, a_we, a_ready, a_rvalid, a_err, a_done;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_valid, b_we, b_ready, b_rvalid, b_err, b_done;
    logic [7:0] b_addr, b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata),
        .rsp_err(a_err), .init_done(a_done));

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata),
        .rsp_err(b_err), .init_done(b_done));

    task automatic drive_a(input logic v, input logic we, input logic [7:0] addr, input logic [7:0] d);
        a_valid = v; a_we = we; a_addr = addr; a_wdata = d;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [7:0] addr, input logic [7:0] d);
        b_valid = v; b_we = we; b_addr = addr; b_wdata = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", a_ready); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", a_done); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b exp 0", a_rvalid); end
        checks++; if (a_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", a_rdata); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", a_err); end
        rst = 1'b0;
        cyc = 0;
        while (a_ready !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 256) begin errors++; $display("FAIL clear_len got %0d exp 256", cyc); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL init_done got %0b exp 1", a_done); end
        // read 0x10 of freshly cleared memory
        drive_a(1'b1, 1'b0, 8'h10, 8'h00);
        a_valid = 1'b0;
        cyc = 1;
        while (a_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (cyc != LAT) begin errors++; $display("FAIL dflt_lat got %0d exp %0d", cyc, LAT); end
        checks++; if (a_rdata !== 8'h00) begin errors++; $display("FAIL dflt_rdata got %h exp 00", a_rdata); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL dflt_err got %0b exp 0", a_err); end
    endtask

    task automatic test_write_read();
        int cyc;
        drive_a(1'b1, 1'b1, 8'h3C, 8'hA5);
        drive_a(1'b1, 1'b0, 8'h3C, 8'h00);
        a_valid = 1'b0;
        cyc = 1;
        while (a_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (cyc != LAT) begin errors++; $display("FAIL wr_rd_lat got %0d exp %0d", cyc, LAT); end
        checks++; if (a_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rd_data got %h exp a5", a_rdata); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL wr_rd_err got %0b exp 0", a_err); end
        @(negedge clk);
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL pulse got %0b exp 0", a_rvalid); end
        checks++; if (a_rdata !== 8'hA5) begin errors++; $display("FAIL hold_data got %h exp a5", a_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] we_seq;
        logic [7:0] exp_d;
        logic       exp_v;
        we_seq = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive_a(1'b1, we_seq[k], 8'h05, (k < 2) ? 8'h11 : 8'h22);
            else       drive_a(1'b0, 1'b0, 8'h00, 8'h00);
            exp_v = (k == LAT) || (k == LAT + 2);
            exp_d = (k == LAT) ? 8'h11 : 8'h22;
            checks++; if (a_rvalid !== exp_v) begin errors++; $display("FAIL b2b_valid k=%0d got %0b exp %0b", k, a_rvalid, exp_v); end
            if (exp_v) begin
                checks++; if (a_rdata !== exp_d) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, a_rdata, exp_d); end
            end
        end
    endtask

    task automatic test_out_of_range();
        int cyc;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b_ready got %0b exp 1", b_ready); end
        drive_b(1'b1, 1'b1, 8'd199, 8'h5A);
        drive_b(1'b1, 1'b0, 8'd199, 8'h00);
        b_valid = 1'b0;
        cyc = 1;
        while (b_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (b_rdata !== 8'h5A || b_err !== 1'b0) begin errors++; $display("FAIL edge_rd1 got %h/%0b exp 5a/0", b_rdata, b_err); end
        drive_b(1'b1, 1'b1, 8'd250, 8'h77);
        drive_b(1'b1, 1'b0, 8'd250, 8'h00);
        b_valid = 1'b0;
        cyc = 1;
        while (b_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (cyc != LAT) begin errors++; $display("FAIL oor_lat got %0d exp %0d", cyc, LAT); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL oor_err got %0b exp 1", b_err); end
        checks++; if (b_rdata !== 8'h00) begin errors++; $display("FAIL oor_data got %h exp 00", b_rdata); end
        @(negedge clk);
        checks++; if (b_err !== 1'b1 || b_rvalid !== 1'b0) begin errors++; $display("FAIL oor_hold got %0b/%0b exp 1/0", b_err, b_rvalid); end
        drive_b(1'b1, 1'b0, 8'd199, 8'h00);
        b_valid = 1'b0;
        cyc = 1;
        while (b_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (b_rdata !== 8'h5A) begin errors++; $display("FAIL edge_rd2 got %h exp 5a", b_rdata); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL edge_err2 got %0b exp 0", b_err); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %0b exp 0", a_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 256) begin errors++; $display("FAIL mid_restart got %0d exp 256", cyc); end
    endtask

    task automatic test_reset_pending();
        int cyc;
        logic seen;
        drive_a(1'b1, 1'b1, 8'h07, 8'hFF);
        drive_a(1'b1, 1'b0, 8'h07, 8'h00);
        a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL cancel got %0b exp 0", a_rvalid); end
        rst = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (a_ready !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (a_rvalid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stray_rsp got %0b exp 0", seen); end
        checks++; if (cyc != 256) begin errors++; $display("FAIL pend_clear got %0d exp 256", cyc); end
        drive_a(1'b1, 1'b0, 8'h07, 8'h00);
        a_valid = 1'b0;
        cyc = 1;
        while (a_rvalid !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        checks++; if (cyc != LAT) begin errors++; $display("FAIL pend_lat got %0d exp %0d", cyc, LAT); end
        checks++; if (a_rdata !== 8'h00) begin errors++; $display("FAIL cleared got %h exp 00", a_rdata); end
    endtask

    task automatic test_stream();
        logic       exp_v;
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) drive_a(1'b1, 1'b1, 8'(i), 8'hC0 + 8'(i));
        for (int k = 0; k < 4 + LAT; k++) begin
            if (k < 4) drive_a(1'b1, 1'b0, 8'(k), 8'h00);
            else       drive_a(1'b0, 1'b0, 8'h00, 8'h00);
            exp_v = (k >= LAT - 1) && (k <= LAT + 2);
            exp_d = 8'hC0 + 8'(k - LAT + 1);
            checks++; if (a_rvalid !== exp_v) begin errors++; $display("FAIL stream_valid k=%0d got %0b exp %0b", k, a_rvalid, exp_v); end
            if (exp_v) begin
                checks++; if (a_rdata !== exp_d) begin errors++; $display("FAIL stream_data k=%0d got %h exp %h", k, a_rdata, exp_d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_clear();
        test_reset_pending();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
